// File: rtl/delay_line_mc.sv
// Multi-channel programmable sample delay line: shared write pointer, per-channel
// delay and fill tracking so a channel never presents samples older than its last restart.
module delay_line_mc #(
  parameter int DATA_WIDTH    = 18,
  parameter int CHANNELS      = 4,
  parameter int DELAY_WIDTH   = 6,
  parameter int DEFAULT_DELAY = 8,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           aclr_n,
  input  logic                           sclr,
  input  logic                           clock_ena,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data,
  input  logic                           delay_wr,
  input  logic [CH_W-1:0]                delay_ch,
  input  logic [DELAY_WIDTH-1:0]         delay_val,
  output logic [CHANNELS*DATA_WIDTH-1:0] q,
  output logic [CHANNELS-1:0]            q_valid
);

  localparam int DEPTH = 2 ** DELAY_WIDTH;

  logic [DATA_WIDTH-1:0]  mem_q  [CHANNELS][DEPTH];
  logic [DELAY_WIDTH-1:0] wp_q, wp_d;
  logic [DELAY_WIDTH-1:0] dly_q  [CHANNELS];
  logic [DELAY_WIDTH-1:0] dly_d  [CHANNELS];
  logic [DELAY_WIDTH-1:0] fill_q [CHANNELS];
  logic [DELAY_WIDTH-1:0] fill_d [CHANNELS];
  logic [DATA_WIDTH-1:0]  q_q    [CHANNELS];
  logic [DATA_WIDTH-1:0]  q_d    [CHANNELS];
  logic [DATA_WIDTH-1:0]  rd_data[CHANNELS];
  logic [DELAY_WIDTH-1:0] rd_addr[CHANNELS];
  logic [CHANNELS-1:0]    vld_q, vld_d;

  // Sample RAM: no reset, contents only become visible once the fill counter vouches for them.
  always_ff @(posedge clock) begin
    if (clock_ena && !sclr) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem_q[c][wp_q] <= data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Zero delay bypasses the RAM since the slot at wp_q is being written this edge.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rd_addr[c] = wp_q - dly_q[c];
      rd_data[c] = (dly_q[c] == '0) ? data[c*DATA_WIDTH +: DATA_WIDTH]
                                    : mem_q[c][rd_addr[c]];
    end
  end

  always_comb begin
    wp_d   = wp_q;
    dly_d  = dly_q;
    fill_d = fill_q;
    q_d    = q_q;
    vld_d  = vld_q;
    if (sclr) begin
      wp_d = '0;
    end else if (clock_ena) begin
      wp_d = wp_q + 1'b1;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      // An out-of-range delay_ch matches no channel, so the write is dropped.
      if (delay_wr && (delay_ch == CH_W'(c))) begin
        dly_d[c]  = delay_val;
        fill_d[c] = '0;
        q_d[c]    = '0;
        vld_d[c]  = 1'b0;
      end else if (sclr) begin
        fill_d[c] = '0;
        q_d[c]    = '0;
        vld_d[c]  = 1'b0;
      end else if (clock_ena) begin
        if (fill_q[c] == dly_q[c]) begin
          q_d[c]   = rd_data[c];
          vld_d[c] = 1'b1;
        end else begin
          fill_d[c] = fill_q[c] + 1'b1;
          q_d[c]    = '0;
          vld_d[c]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wp_q  <= '0;
      vld_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        dly_q[c]  <= DELAY_WIDTH'(DEFAULT_DELAY);
        fill_q[c] <= '0;
        q_q[c]    <= '0;
      end
    end else begin
      wp_q   <= wp_d;
      vld_q  <= vld_d;
      dly_q  <= dly_d;
      fill_q <= fill_d;
      q_q    <= q_d;
    end
  end

  always_comb begin
    q = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      q[c*DATA_WIDTH +: DATA_WIDTH] = q_q[c];
    end
  end

  assign q_valid = vld_q;

endmodule

// File: tb/tb_delay_line_mc.sv
// Directed bench for delay_line_mc: a default-parameter instance plus a small
// 3-channel instance where an out-of-range delay_ch is representable.
module tb_delay_line_mc;

  logic        clock = 1'b0;
  logic        aclr_n, sclr, clock_ena;
  logic [71:0] data;
  logic        delay_wr;
  logic [1:0]  delay_ch;
  logic [5:0]  delay_val;
  logic [71:0] q;
  logic [3:0]  q_valid;

  logic [23:0] s_data;
  logic        s_wr;
  logic [1:0]  s_ch;
  logic [2:0]  s_val;
  logic [23:0] s_q;
  logic [2:0]  s_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;
  int rb[4], db[4];
  int rs[3], ds[3];

  delay_line_mc u_dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .clock_ena(clock_ena),
    .data(data), .delay_wr(delay_wr), .delay_ch(delay_ch), .delay_val(delay_val),
    .q(q), .q_valid(q_valid)
  );

  delay_line_mc #(.DATA_WIDTH(8), .CHANNELS(3), .DELAY_WIDTH(3), .DEFAULT_DELAY(2)) u_small (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .clock_ena(clock_ena),
    .data(s_data), .delay_wr(s_wr), .delay_ch(s_ch), .delay_val(s_val),
    .q(s_q), .q_valid(s_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] big_lanes(int k);
    logic [71:0] v = '0;
    for (int c = 0; c < 4; c++) v[c*18 +: 18] = 18'(c*4096 + k);
    return v;
  endfunction

  function automatic logic [23:0] small_lanes(int k);
    logic [23:0] v = '0;
    for (int c = 0; c < 3; c++) v[c*8 +: 8] = 8'(c*40 + k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A channel restarted after enabled sample r with delay D shows sample n-D once n >= r+D+1.
  task automatic check_all(input string tag);
    logic [71:0] eq  = '0;
    logic [3:0]  ev  = '0;
    logic [23:0] esq = '0;
    logic [2:0]  esv = '0;
    for (int c = 0; c < 4; c++) begin
      if (n >= rb[c] + db[c] + 1) begin
        eq[c*18 +: 18] = 18'(c*4096 + n - db[c]);
        ev[c] = 1'b1;
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (n >= rs[c] + ds[c] + 1) begin
        esq[c*8 +: 8] = 8'(c*40 + n - ds[c]);
        esv[c] = 1'b1;
      end
    end
    chk({tag, ".q"},       128'(q),       128'(eq));
    chk({tag, ".q_valid"}, 128'(q_valid), 128'(ev));
    chk({tag, ".s_q"},     128'(s_q),     128'(esq));
    chk({tag, ".s_valid"}, 128'(s_valid), 128'(esv));
  endtask

  task automatic edge_step(input string tag, input bit ena, input bit sc,
                           input bit wr, input int ch, input int dv,
                           input bit swr, input int sch, input int sdv);
    bit inc = ena && !sc;
    clock_ena = ena;
    sclr      = sc;
    data      = inc ? big_lanes(n + 1) : '1;
    s_data    = inc ? small_lanes(n + 1) : '1;
    delay_wr  = wr;  delay_ch = 2'(ch);  delay_val = 6'(dv);
    s_wr      = swr; s_ch     = 2'(sch); s_val     = 3'(sdv);
    @(posedge clock);
    #1;
    if (inc) n++;
    if (sc) begin
      for (int c = 0; c < 4; c++) rb[c] = n;
      for (int c = 0; c < 3; c++) rs[c] = n;
    end
    if (wr && ch < 4) begin db[ch] = dv; rb[ch] = n; end
    if (swr && sch < 3) begin ds[sch] = sdv; rs[sch] = n; end
    delay_wr = 1'b0;
    s_wr     = 1'b0;
    sclr     = 1'b0;
    check_all(tag);
  endtask

  task automatic reset_model();
    for (int c = 0; c < 4; c++) begin rb[c] = n; db[c] = 8; end
    for (int c = 0; c < 3; c++) begin rs[c] = n; ds[c] = 2; end
  endtask

  initial begin
    aclr_n = 1'b0; sclr = 1'b0; clock_ena = 1'b0; data = '0; s_data = '0;
    delay_wr = 1'b0; delay_ch = '0; delay_val = '0;
    s_wr = 1'b0; s_ch = '0; s_val = '0;
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    aclr_n = 1'b1;

    // Default delay 8: valid on 9th enabled edge with sample 1.
    for (int i = 0; i < 20; i++) edge_step("ramp", 1, 0, 0, 0, 0, 0, 0, 0);

    // Ch2 to zero delay; small instance gets an out-of-range write that must be dropped.
    edge_step("ld_ch2_d0", 1, 0, 1, 2, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) edge_step("ch2_d0", 1, 0, 0, 0, 0, 0, 0, 0);

    // Ch3 to delay 2, small ch1 to its maximum delay 7, then an enable gap.
    edge_step("ld_ch3_d2", 1, 0, 1, 3, 2, 1, 1, 7);
    for (int i = 0; i < 3; i++) edge_step("ch3_fill", 1, 0, 0, 0, 0, 0, 0, 0);
    edge_step("gap_en1", 1, 0, 0, 0, 0, 0, 0, 0);
    edge_step("gap_idle1", 0, 0, 0, 0, 0, 0, 0, 0);
    edge_step("gap_idle2", 0, 0, 0, 0, 0, 0, 0, 0);
    edge_step("gap_en2", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) edge_step("small_max", 1, 0, 0, 0, 0, 0, 0, 0);

    // Ch1 to maximum delay 63 mid-stream: exercises full pointer wrap.
    edge_step("ld_ch1_d63", 1, 0, 1, 1, 63, 0, 0, 0);
    for (int i = 0; i < 67; i++) edge_step("ch1_d63", 1, 0, 0, 0, 0, 0, 0, 0);

    // Ch0 delay 3, then sclr with a coincident delay load on ch3.
    edge_step("ld_ch0_d3", 1, 0, 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) edge_step("pre_sclr", 1, 0, 0, 0, 0, 0, 0, 0);
    edge_step("sclr", 1, 1, 1, 3, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) edge_step("post_sclr", 1, 0, 0, 0, 0, 0, 0, 0);
    edge_step("idle_sclr", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) edge_step("post_sclr2", 1, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges: outputs clear without waiting for a clock.
    #3;
    aclr_n = 1'b0;
    #1;
    chk("aclr_async.q",       128'(q),       128'(0));
    chk("aclr_async.q_valid", 128'(q_valid), 128'(0));
    chk("aclr_async.s_q",     128'(s_q),     128'(0));
    chk("aclr_async.s_valid", 128'(s_valid), 128'(0));
    reset_model();
    @(posedge clock);
    #1;
    check_all("aclr_held");
    aclr_n = 1'b1;
    for (int i = 0; i < 4; i++) edge_step("post_aclr", 1, 0, 0, 0, 0, 0, 0, 0);
    edge_step("oor_after_aclr", 1, 0, 0, 0, 0, 1, 3, 5);
    for (int i = 0; i < 7; i++) edge_step("post_aclr2", 1, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
